password_writer: RTL
====================

PASSWORD_WRITER -- requirements
Module: password_writer

Interface
REQ-001 Parameter: DIGITS, 6, number of 4-bit password digits per entry; fixed stored word width 4*DIGITS = 24.
REQ-002 Parameter: RETRY_MAX, 1, number of write re-attempts after a failed readback.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 ChangeRequest  input  1  one-cycle pulse from game controller requesting password change.
REQ-006 LoggedIn  input  1  level, high while a user session is active.
REQ-007 isGuest  input  1  level, high when current session is the guest account.
REQ-008 PlayerAddress  input  5  password memory address of current user.
REQ-009 PasswordSwitch  input  4  current digit value.
REQ-010 PasswordButton  input  1  one-cycle debounced pulse, digit-enter strobe.
REQ-011 RAM_Q  input  24  password memory read data, valid 2 cycles after address is registered.
REQ-012 RAM_Address  output  5  password memory address.
REQ-013 RAM_Data  output  24  password memory write data.
REQ-014 RAM_WrEn  output  1  password memory write enable, active-high.
REQ-015 Busy  output  1  high in every state except IDLE.
REQ-016 WriteDone  output  1  one-cycle pulse, new password stored and verified.
REQ-017 WriteFail  output  1  one-cycle pulse, change rejected or aborted.

Function
REQ-018 States: IDLE, ENTRY1, ENTRY2, COMPARE, WRITE, READ, WAIT1, WAIT2, VERIFY; any other encoding SHALL go to IDLE next cycle.
REQ-019 IDLE: on ChangeRequest=1 with LoggedIn=1 and isGuest=0 -> latch PlayerAddress into an internal register, clear digit counter, go ENTRY1; with isGuest=1 or LoggedIn=0 -> WriteFail pulse, stay IDLE.
REQ-020 ENTRY1: each PasswordButton pulse stores PasswordSwitch MSB-first (first digit into [23:20]); after the 6th digit -> ENTRY2 with counter cleared.
REQ-021 ENTRY2: same capture into a second 24-bit confirm register; after the 6th digit -> COMPARE.
REQ-022 COMPARE (1 cycle): entries equal -> WRITE; unequal -> WriteFail pulse, IDLE, no memory write.
REQ-023 WRITE (1 cycle): RAM_WrEn=1, RAM_Address=latched address, RAM_Data=entry1 -> READ.
REQ-024 READ: RAM_WrEn=0, address held -> WAIT1 -> WAIT2 -> VERIFY; VERIFY samples RAM_Q.
REQ-025 VERIFY: RAM_Q == entry1 -> WriteDone pulse, IDLE; mismatch with retry count < RETRY_MAX -> increment count, WRITE; otherwise WriteFail pulse, IDLE.
REQ-026 Latency from 6th confirm digit to WriteDone: exactly 7 cycles on first-attempt success.
REQ-027 LoggedIn=0 in any state from ENTRY1 through WAIT2 -> abort to IDLE next cycle with WriteFail pulse; if sampled in the WRITE cycle, that one write has already been issued.
REQ-028 ChangeRequest outside IDLE and PasswordButton outside ENTRY1/ENTRY2 are ignored.
REQ-029 RAM_Address SHALL hold the latched address from WRITE through VERIFY, independent of PlayerAddress changes.
REQ-030 WriteDone and WriteFail are never high in the same cycle; RAM_WrEn is high only in WRITE.

Reset
REQ-031 rst low asynchronously forces IDLE, Busy=0, RAM_WrEn=0, WriteDone=0, WriteFail=0, RAM_Address=0, RAM_Data=0, digit counter, retry count and both entry registers to 0.
REQ-032 Reset mid-operation discards entered digits; no write is issued after rst deasserts until a new ChangeRequest.

Verification
REQ-033 Addr 5'd3, enter 1,2,3,4,5,6 twice, RAM returns 24'h123456 -> one RAM_WrEn pulse with Data 24'h123456, Addr 3; WriteDone 7 cycles after last digit.
REQ-034 Entry1 24'h123456, entry2 24'h123457 -> WriteFail pulse after COMPARE, RAM_WrEn never asserted.
REQ-035 isGuest=1 with ChangeRequest -> WriteFail next cycle, Busy stays 0.
REQ-036 RAM_Q forced 24'h000000 on both readbacks -> exactly 2 write pulses, then WriteFail.
REQ-037 LoggedIn dropped after 3 ENTRY2 digits -> WriteFail, IDLE, no write; rst pulsed during WAIT1 -> all outputs 0 immediately.

Source files
------------

// File: rtl/password_writer.sv
// Password change controller: double entry, compare, write, readback verify.
// Drives a password RAM with a fixed two-cycle read latency.
module password_writer #(
  parameter int DIGITS    = 6,
  parameter int RETRY_MAX = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ChangeRequest,
  input  logic                  LoggedIn,
  input  logic                  isGuest,
  input  logic [4:0]            PlayerAddress,
  input  logic [3:0]            PasswordSwitch,
  input  logic                  PasswordButton,
  input  logic [4*DIGITS-1:0]   RAM_Q,
  output logic [4:0]            RAM_Address,
  output logic [4*DIGITS-1:0]   RAM_Data,
  output logic                  RAM_WrEn,
  output logic                  Busy,
  output logic                  WriteDone,
  output logic                  WriteFail
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  localparam int RW = $clog2(RETRY_MAX + 2);

  typedef enum logic [3:0] {
    IDLE, ENTRY1, ENTRY2, COMPARE, WRITE,
    READ, WAIT1, WAIT2, VERIFY
  } state_t;

  state_t          state, state_nxt;
  logic [4:0]      addr_q, addr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic [W-1:0]    entry1_q, entry1_d;
  logic [W-1:0]    entry2_q, entry2_d;
  logic            done_q, done_d;
  logic            fail_q, fail_d;
  logic            last_digit;

  assign last_digit = (cnt_q == CW'(DIGITS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      retry_q  <= '0;
      entry1_q <= '0;
      entry2_q <= '0;
      done_q   <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      retry_q  <= retry_d;
      entry1_q <= entry1_d;
      entry2_q <= entry2_d;
      done_q   <= done_d;
      fail_q   <= fail_d;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    retry_d   = retry_q;
    entry1_d  = entry1_q;
    entry2_d  = entry2_q;
    done_d    = 1'b0;
    fail_d    = 1'b0;
    case (state)
      IDLE: begin
        if (ChangeRequest) begin
          if (LoggedIn && !isGuest) begin
            addr_d    = PlayerAddress;
            cnt_d     = '0;
            retry_d   = '0;
            state_nxt = ENTRY1;
          end else begin
            fail_d = 1'b1;
          end
        end
      end
      ENTRY1: begin
        if (PasswordButton) begin
          entry1_d = {entry1_q[W-5:0], PasswordSwitch};
          if (last_digit) begin
            cnt_d     = '0;
            state_nxt = ENTRY2;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ENTRY2: begin
        if (PasswordButton) begin
          entry2_d = {entry2_q[W-5:0], PasswordSwitch};
          if (last_digit) begin
            cnt_d     = '0;
            state_nxt = COMPARE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      COMPARE: begin
        if (entry1_q == entry2_q) begin
          state_nxt = WRITE;
        end else begin
          fail_d    = 1'b1;
          state_nxt = IDLE;
        end
      end
      WRITE: state_nxt = READ;
      READ:  state_nxt = WAIT1;
      WAIT1: state_nxt = WAIT2;
      WAIT2: state_nxt = VERIFY;
      VERIFY: begin
        if (RAM_Q == entry1_q) begin
          done_d    = 1'b1;
          state_nxt = IDLE;
        end else if (retry_q < RW'(RETRY_MAX)) begin
          retry_d   = retry_q + RW'(1);
          state_nxt = WRITE;
        end else begin
          fail_d    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Session loss wins over any progress made this cycle.
    if (!LoggedIn && (state inside {ENTRY1, ENTRY2, COMPARE,
                                    WRITE, READ, WAIT1, WAIT2})) begin
      state_nxt = IDLE;
      done_d    = 1'b0;
      fail_d    = 1'b1;
    end
  end

  assign RAM_WrEn    = (state == WRITE);
  assign RAM_Address = addr_q;
  assign RAM_Data    = (state == WRITE) ? entry1_q : '0;
  assign Busy        = (state != IDLE);
  assign WriteDone   = done_q;
  assign WriteFail   = fail_q;

endmodule
